// File: rtl/mctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: FSM state encoding,
// opcode/funct values, ALU operation codes and datapath mux encodings.
package mctrl_pkg;

  // FSM states; loads and stores get separate address states so the
  // opcode only has to be looked at once, in DECODE.
  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC_R  = 4'd3,
    ST_WB_R    = 4'd4,
    ST_EXEC_I  = 4'd5,
    ST_WB_I    = 4'd6,
    ST_ADDR_LD = 4'd7,
    ST_ADDR_ST = 4'd8,
    ST_MEM_RD  = 4'd9,
    ST_WB_MEM  = 4'd10,
    ST_MEM_WR  = 4'd11,
    ST_BRANCH  = 4'd12,
    ST_JUMP    = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_NOP = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // The all-zero instruction word retires in DECODE without touching state.
  function automatic logic is_nop(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_NOP);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to the ALU operation and
// flags whether the funct belongs to the supported subset.
module mc_alu_decoder
  import mctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_cntrl,
  output logic       o_funct_legal
);

  // Table lookup; unsupported functs fall back to ADD and are flagged illegal.
  always_comb begin
    o_alu_cntrl   = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_cntrl = ALU_ADD;
      FN_SUB:  o_alu_cntrl = ALU_SUB;
      FN_AND:  o_alu_cntrl = ALU_AND;
      FN_OR:   o_alu_cntrl = ALU_OR;
      FN_SLT:  o_alu_cntrl = ALU_SLT;
      default: o_funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle MIPS datapath.
// Optional feature: define MCTRL_PERF_EN to add retired-instruction and
// memory-stall counters (instr_cnt, stall_cnt, CNT_W bits, wrapping).
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op_in,
  input  logic [5:0]       func_in,
  input  logic             zero_in,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_cntrl,
  output logic             illegal_op
`ifdef MCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] w_alu_r;
  logic       w_funct_legal;

  // The branch decision (pc_write_cond & zero) is resolved in the datapath;
  // the controller itself is pure Moore and never looks at the zero flag.
  logic w_unused_zero;
  assign w_unused_zero = zero_in;

  mc_alu_decoder u_alu_dec (
    .i_funct       (func_in),
    .o_alu_cntrl   (w_alu_r),
    .o_funct_legal (w_funct_legal)
  );

  // State register, cleared to IDLE the instant reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and per-state control outputs; everything idles at 0 by default.
  always_comb begin
    w_state_next  = ST_IDLE;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_cntrl     = ALU_ADD;
    illegal_op    = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        // Read instruction at PC while computing PC+4; commit both on ready.
        mem_read     = 1'b1;
        alu_src_b    = SRCB_FOUR;
        w_state_next = ST_FETCH;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b    = SRCB_BOFF;
        w_state_next = ST_FETCH;
        case (op_in)
          OP_RTYPE: begin
            if (w_funct_legal)                w_state_next = ST_EXEC_R;
            else if (!is_nop(op_in, func_in)) illegal_op   = 1'b1;
          end
          OP_LW:   w_state_next = ST_ADDR_LD;
          OP_SW:   w_state_next = ST_ADDR_ST;
          OP_ADDI: w_state_next = ST_EXEC_I;
          OP_BEQ:  w_state_next = ST_BRANCH;
          OP_J:    w_state_next = ST_JUMP;
          default: illegal_op   = 1'b1;
        endcase
      end
      ST_EXEC_R: begin
        alu_src_a    = 1'b1;
        alu_cntrl    = w_alu_r;
        w_state_next = ST_WB_R;
      end
      ST_WB_R: begin
        reg_dst      = 1'b1;
        reg_write    = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = ST_WB_I;
      end
      ST_WB_I: begin
        reg_write    = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_ADDR_LD, ST_ADDR_ST: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = (r_state == ST_ADDR_LD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read     = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = mem_ready ? ST_WB_MEM : ST_MEM_RD;
      end
      ST_WB_MEM: begin
        mem_to_reg   = 1'b1;
        reg_write    = 1'b1;
        w_state_next = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write    = 1'b1;
        i_or_d       = 1'b1;
        w_state_next = mem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_cntrl     = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        w_state_next  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = PCSRC_JUMP;
        w_state_next = ST_FETCH;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] r_instr_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_retire;
  logic             w_stall;

  // Retire = the cycle in which an instruction's final state is left.
  always_comb begin
    w_retire = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: w_retire = 1'b1;
      ST_MEM_WR: begin
        w_retire = mem_ready;
        w_stall  = !mem_ready;
      end
      ST_DECODE:           w_retire = is_nop(op_in, func_in);
      ST_FETCH, ST_MEM_RD: w_stall  = !mem_ready;
      default: ;
    endcase
  end

  // Free-running wrapping counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_retire) r_instr_cnt <= r_instr_cnt + 1'b1;
      if (w_stall)  r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign instr_cnt = r_instr_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks each instruction class through
// the FSM cycle by cycle and compares the packed control word per state.
// Counter checks are compiled in when MCTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op_in;
  logic [5:0] func_in;
  logic       zero_in;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, reg_write, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_cntrl;
`ifdef MCTRL_PERF_EN
  logic [CNT_W-1:0] instr_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_in         (op_in),
    .func_in       (func_in),
    .zero_in       (zero_in),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_cntrl     (alu_cntrl),
    .illegal_op    (illegal_op)
`ifdef MCTRL_PERF_EN
    ,
    .instr_cnt     (instr_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Packed control word:
  // {pw, pwc, ps[1:0], iod, mr, mw, irw, rd, rw, m2r, sa, sb[1:0], ac[3:0], ill}
  function automatic logic [18:0] mk(
      input logic pw, input logic pwc, input logic [1:0] ps, input logic iod,
      input logic mr, input logic mw, input logic irw, input logic rd,
      input logic rw, input logic m2r, input logic sa, input logic [1:0] sb,
      input logic [3:0] ac, input logic ill);
    return {pw, pwc, ps, iod, mr, mw, irw, rd, rw, m2r, sa, sb, ac, ill};
  endfunction

  //                                         pw pwc ps    iod mr mw irw rd rw m2r sa sb     ac       ill
  localparam logic [18:0] E_IDLE    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_FETCH_W = mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 4'b0000, 0);
  localparam logic [18:0] E_FETCH_R = mk(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 4'b0000, 0);
  localparam logic [18:0] E_DEC     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 0);
  localparam logic [18:0] E_DEC_ILL = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0000, 1);
  localparam logic [18:0] E_EXR_ADD = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_EXR_SUB = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0001, 0);
  localparam logic [18:0] E_EXR_SLT = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0100, 0);
  localparam logic [18:0] E_WB_R    = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_EXI     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 0);
  localparam logic [18:0] E_WB_I    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_ADDR    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 4'b0000, 0);
  localparam logic [18:0] E_MEM_RD  = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_WB_MEM  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_MEM_WR  = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
  localparam logic [18:0] E_BRANCH  = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0001, 0);
  localparam logic [18:0] E_JUMP    = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);

  logic [18:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b,
                 alu_cntrl, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One cycle: drive inputs in the low phase, check the control word, move on.
  task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input logic [18:0] exp);
    mem_ready = rdy;
    op_in     = op;
    func_in   = fn;
    #1;
    check(tag, {13'd0, ctrl}, {13'd0, exp});
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    op_in     = 6'd0;
    func_in   = 6'd0;
    zero_in   = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {13'd0, ctrl}, {13'd0, E_IDLE});

    // Release, IDLE then FETCH waiting on memory.
    rst_n = 1'b1;
    step("idle_after_rst", 1'b0, 6'd0, 6'd0, E_IDLE);
    step("fetch_wait", 1'b0, 6'd0, 6'd0, E_FETCH_W);

    // Reset asserted mid-FETCH: outputs drop without waiting for a clock.
    mem_ready = 1'b0;
    #1 check("fetch_before_rst", {13'd0, ctrl}, {13'd0, E_FETCH_W});
    #1 rst_n = 1'b0;
    #1 check("async_rst_clear", {13'd0, ctrl}, {13'd0, E_IDLE});
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_again", 1'b0, 6'd0, 6'd0, E_IDLE);
    step("fetch_wait2", 1'b0, 6'd0, 6'd0, E_FETCH_W);

    // ADD: 4 cycles.
    step("add_fetch", 1'b1, 6'b000000, 6'b100000, E_FETCH_R);
    step("add_decode", 1'b1, 6'b000000, 6'b100000, E_DEC);
    step("add_exec", 1'b1, 6'b000000, 6'b100000, E_EXR_ADD);
    step("add_wb", 1'b1, 6'b000000, 6'b100000, E_WB_R);

    // SUB and SLT: ALU code follows funct in EXEC_R.
    step("sub_fetch", 1'b1, 6'b000000, 6'b100010, E_FETCH_R);
    step("sub_decode", 1'b1, 6'b000000, 6'b100010, E_DEC);
    step("sub_exec", 1'b1, 6'b000000, 6'b100010, E_EXR_SUB);
    step("sub_wb", 1'b1, 6'b000000, 6'b100010, E_WB_R);
    step("slt_fetch", 1'b1, 6'b000000, 6'b101010, E_FETCH_R);
    step("slt_decode", 1'b1, 6'b000000, 6'b101010, E_DEC);
    step("slt_exec", 1'b1, 6'b000000, 6'b101010, E_EXR_SLT);
    step("slt_wb", 1'b1, 6'b000000, 6'b101010, E_WB_R);

    // LW with 3 wait cycles in MEM_RD; opcode garbage after DECODE is ignored.
    step("lw_fetch", 1'b1, 6'b100011, 6'd0, E_FETCH_R);
    step("lw_decode", 1'b1, 6'b100011, 6'd0, E_DEC);
    step("lw_addr", 1'b1, 6'b111111, 6'd0, E_ADDR);
    step("lw_memrd_w1", 1'b0, 6'b111111, 6'd0, E_MEM_RD);
    step("lw_memrd_w2", 1'b0, 6'b101011, 6'd0, E_MEM_RD);
    step("lw_memrd_w3", 1'b0, 6'b111111, 6'd0, E_MEM_RD);
    step("lw_memrd_rdy", 1'b1, 6'b111111, 6'd0, E_MEM_RD);
    step("lw_wb", 1'b1, 6'b111111, 6'd0, E_WB_MEM);

    // ADDI: 4 cycles.
    step("addi_fetch", 1'b1, 6'b001000, 6'd0, E_FETCH_R);
    step("addi_decode", 1'b1, 6'b001000, 6'd0, E_DEC);
    step("addi_exec", 1'b1, 6'b001000, 6'd0, E_EXI);
    step("addi_wb", 1'b1, 6'b001000, 6'd0, E_WB_I);

    // BEQ taken and not taken: controller outputs identical, 3 cycles each.
    zero_in = 1'b1;
    step("beq1_fetch", 1'b1, 6'b000100, 6'd0, E_FETCH_R);
    step("beq1_decode", 1'b1, 6'b000100, 6'd0, E_DEC);
    step("beq1_branch", 1'b1, 6'b000100, 6'd0, E_BRANCH);
    zero_in = 1'b0;
    step("beq0_fetch", 1'b1, 6'b000100, 6'd0, E_FETCH_R);
    step("beq0_decode", 1'b1, 6'b000100, 6'd0, E_DEC);
    step("beq0_branch", 1'b1, 6'b000100, 6'd0, E_BRANCH);

    // Illegal opcode and illegal R-type funct: pulse in DECODE, back to FETCH.
    step("ill_op_fetch", 1'b1, 6'b111111, 6'd0, E_FETCH_R);
    step("ill_op_decode", 1'b1, 6'b111111, 6'd0, E_DEC_ILL);
    step("ill_fn_fetch", 1'b1, 6'b000000, 6'b000001, E_FETCH_R);
    step("ill_fn_decode", 1'b1, 6'b000000, 6'b000001, E_DEC_ILL);

    // NOP: 2 cycles, no pulse.
    step("nop_fetch", 1'b1, 6'd0, 6'd0, E_FETCH_R);
    step("nop_decode", 1'b1, 6'd0, 6'd0, E_DEC);

    // SW with 2 waits.
    step("sw_fetch", 1'b1, 6'b101011, 6'd0, E_FETCH_R);
    step("sw_decode", 1'b1, 6'b101011, 6'd0, E_DEC);
    step("sw_addr", 1'b1, 6'b100011, 6'd0, E_ADDR);
    step("sw_memwr_w1", 1'b0, 6'b100011, 6'd0, E_MEM_WR);
    step("sw_memwr_w2", 1'b0, 6'b100011, 6'd0, E_MEM_WR);
    step("sw_memwr_rdy", 1'b1, 6'b100011, 6'd0, E_MEM_WR);

    // J: 3 cycles, then back to a FETCH.
    step("j_fetch", 1'b1, 6'b000010, 6'd0, E_FETCH_R);
    step("j_decode", 1'b1, 6'b000010, 6'd0, E_DEC);
    step("j_jump", 1'b1, 6'b000010, 6'd0, E_JUMP);
    step("after_j_fetch", 1'b0, 6'd0, 6'd0, E_FETCH_W);

`ifdef MCTRL_PERF_EN
    // Fresh run: ADD, SW (2 waits), J, NOP -> 4 retired, 2 stalls.
    rst_n = 1'b0;
    @(negedge clk);
    check("perf_rst_instr", instr_cnt, 32'd0);
    check("perf_rst_stall", stall_cnt, 32'd0);
    rst_n = 1'b1;
    step("p_idle", 1'b1, 6'd0, 6'd0, E_IDLE);
    step("p_add_fetch", 1'b1, 6'b000000, 6'b100000, E_FETCH_R);
    step("p_add_decode", 1'b1, 6'b000000, 6'b100000, E_DEC);
    step("p_add_exec", 1'b1, 6'b000000, 6'b100000, E_EXR_ADD);
    step("p_add_wb", 1'b1, 6'b000000, 6'b100000, E_WB_R);
    step("p_sw_fetch", 1'b1, 6'b101011, 6'd0, E_FETCH_R);
    step("p_sw_decode", 1'b1, 6'b101011, 6'd0, E_DEC);
    step("p_sw_addr", 1'b1, 6'b101011, 6'd0, E_ADDR);
    step("p_sw_w1", 1'b0, 6'b101011, 6'd0, E_MEM_WR);
    step("p_sw_w2", 1'b0, 6'b101011, 6'd0, E_MEM_WR);
    step("p_sw_rdy", 1'b1, 6'b101011, 6'd0, E_MEM_WR);
    step("p_j_fetch", 1'b1, 6'b000010, 6'd0, E_FETCH_R);
    step("p_j_decode", 1'b1, 6'b000010, 6'd0, E_DEC);
    step("p_j_jump", 1'b1, 6'b000010, 6'd0, E_JUMP);
    step("p_nop_fetch", 1'b1, 6'd0, 6'd0, E_FETCH_R);
    step("p_nop_decode", 1'b1, 6'd0, 6'd0, E_DEC);
    #1;
    check("perf_instr_cnt", instr_cnt, 32'd4);
    check("perf_stall_cnt", stall_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
